// File: rtl/net_pkg.sv
// Shared AXI-Stream widths, buffer word layout and write-FSM state encoding
// for the 10G RX datapath.
package net_pkg;

    localparam int AXIS_DATA_W = 64;
    localparam int AXIS_KEEP_W = 8;
    localparam int RX_WORD_W   = AXIS_DATA_W + AXIS_KEEP_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } wr_state_t;

    typedef struct packed {
        logic                   last;
        logic [AXIS_KEEP_W-1:0] keep;
        logic [AXIS_DATA_W-1:0] data;
    } rx_word_t;

endpackage

// File: rtl/rx_frame_buffer_if.sv
// AXI-Stream beat bundle used on both sides of the RX frame buffer.
interface rx_frame_buffer_if;
    import net_pkg::*;

    logic [AXIS_DATA_W-1:0] tdata;
    logic [AXIS_KEEP_W-1:0] tkeep;
    logic                   tvalid;
    logic                   tlast;
    logic                   tuser;
    logic                   tready;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);

endinterface

// File: rtl/rx_frame_buffer_ram.sv
// Simple dual-port RAM, one write and one read port, registered read data.
module rx_frame_buffer_ram #(
    parameter int DEPTH_LOG2 = 9,
    parameter int WIDTH      = 73
) (
    input  logic                  clk156,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [0:(2**DEPTH_LOG2)-1];

    // rd_data only changes on rd_en, so it doubles as the stall-hold register.
    always_ff @(posedge clk156) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/rx_frame_buffer.sv
// Store-and-forward RX buffer: only complete good frames are forwarded.
// Define RX_DROP_STATS_EN to add saturating overflow / bad-frame counters.
module rx_frame_buffer
    import net_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic               clk156,
    input  logic               reset,
    rx_frame_buffer_if.slave   s_axis,
    rx_frame_buffer_if.master  m_axis,
    output logic               rx_fifo_overflow,
    output logic               rx_bad_frame
`ifdef RX_DROP_STATS_EN
    ,
    output logic [31:0]        rx_overflow_count,
    output logic [31:0]        rx_bad_count
`endif
);

    localparam int PTR_W = DEPTH_LOG2 + 1;
    localparam logic [PTR_W-1:0] DEPTH_BEATS = {1'b1, {DEPTH_LOG2{1'b0}}};

    wr_state_t        state_reg, state_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] commit_ptr_reg, commit_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic             ovf_reg, ovf_next;
    logic             bad_reg, bad_next;
    logic             out_valid_reg, out_valid_next;
    logic             full;
    logic             wr_en;
    logic             rd_en;
    rx_word_t         wr_word;
    rx_word_t         rd_word;

    // The MAC cannot be throttled.
    assign s_axis.tready = 1'b1;

    assign full    = (wr_ptr_reg - rd_ptr_reg) == DEPTH_BEATS;
    assign wr_word = {s_axis.tlast, s_axis.tkeep, s_axis.tdata};

    always_comb begin
        state_next      = state_reg;
        wr_ptr_next     = wr_ptr_reg;
        commit_ptr_next = commit_ptr_reg;
        wr_en           = 1'b0;
        ovf_next        = 1'b0;
        bad_next        = 1'b0;
        if (s_axis.tvalid) begin
            case (state_reg)
                IDLE, PASS: begin
                    if (full) begin
                        wr_ptr_next = commit_ptr_reg;
                        ovf_next    = 1'b1;
                        state_next  = s_axis.tlast ? IDLE : DROP;
                    end else begin
                        wr_en = 1'b1;
                        if (!s_axis.tlast) begin
                            wr_ptr_next = wr_ptr_reg + 1'b1;
                            state_next  = PASS;
                        end else if (s_axis.tuser) begin
                            wr_ptr_next = commit_ptr_reg;
                            bad_next    = 1'b1;
                            state_next  = IDLE;
                        end else begin
                            wr_ptr_next     = wr_ptr_reg + 1'b1;
                            commit_ptr_next = wr_ptr_reg + 1'b1;
                            state_next      = IDLE;
                        end
                    end
                end
                DROP: begin
                    if (s_axis.tlast) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Fetch the next committed beat whenever the output slot is free or draining.
    always_comb begin
        rd_en          = (rd_ptr_reg != commit_ptr_reg) && (!out_valid_reg || m_axis.tready);
        rd_ptr_next    = rd_en ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
        out_valid_next = out_valid_reg;
        if (rd_en) begin
            out_valid_next = 1'b1;
        end else if (m_axis.tready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            wr_ptr_reg     <= '0;
            commit_ptr_reg <= '0;
            rd_ptr_reg     <= '0;
            ovf_reg        <= 1'b0;
            bad_reg        <= 1'b0;
            out_valid_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wr_ptr_reg     <= wr_ptr_next;
            commit_ptr_reg <= commit_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            ovf_reg        <= ovf_next;
            bad_reg        <= bad_next;
            out_valid_reg  <= out_valid_next;
        end
    end

    rx_frame_buffer_ram #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .WIDTH     (RX_WORD_W)
    ) u_ram (
        .clk156 (clk156),
        .wr_en  (wr_en),
        .wr_addr(wr_ptr_reg[DEPTH_LOG2-1:0]),
        .wr_data(wr_word),
        .rd_en  (rd_en),
        .rd_addr(rd_ptr_reg[DEPTH_LOG2-1:0]),
        .rd_data(rd_word)
    );

    // Masked so the bus reads as zero whenever no beat is presented.
    assign m_axis.tvalid = out_valid_reg;
    assign m_axis.tdata  = out_valid_reg ? rd_word.data : '0;
    assign m_axis.tkeep  = out_valid_reg ? rd_word.keep : '0;
    assign m_axis.tlast  = out_valid_reg & rd_word.last;
    assign m_axis.tuser  = 1'b0;

    assign rx_fifo_overflow = ovf_reg;
    assign rx_bad_frame     = bad_reg;

`ifdef RX_DROP_STATS_EN
    logic [1:0] drop_pulse;
    assign drop_pulse = {bad_reg, ovf_reg};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_drop_cnt
            logic [31:0] count_reg;
            always_ff @(posedge clk156 or posedge reset) begin
                if (reset) begin
                    count_reg <= '0;
                end else if (drop_pulse[gi] && (count_reg != 32'hFFFF_FFFF)) begin
                    count_reg <= count_reg + 1'b1;
                end
            end
        end
    endgenerate

    assign rx_overflow_count = gen_drop_cnt[0].count_reg;
    assign rx_bad_count      = gen_drop_cnt[1].count_reg;
`endif

endmodule

// File: tb/tb_rx_frame_buffer.sv
// Self-checking bench for rx_frame_buffer: frame-level queue model plus
// directed latency, drop, backpressure, wrap and reset scenarios.
module tb_rx_frame_buffer;
    import net_pkg::*;

    localparam int DL2 = 4;

    typedef struct packed {
        logic        last;
        logic [7:0]  keep;
        logic [63:0] data;
    } beat_t;

    logic clk156 = 1'b0;
    logic reset  = 1'b1;
    logic rx_fifo_overflow;
    logic rx_bad_frame;
`ifdef RX_DROP_STATS_EN
    logic [31:0] rx_overflow_count;
    logic [31:0] rx_bad_count;
`endif

    rx_frame_buffer_if s_if ();
    rx_frame_buffer_if m_if ();

    rx_frame_buffer #(.DEPTH_LOG2(DL2)) dut (
        .clk156          (clk156),
        .reset           (reset),
        .s_axis          (s_if),
        .m_axis          (m_if),
        .rx_fifo_overflow(rx_fifo_overflow),
        .rx_bad_frame    (rx_bad_frame)
`ifdef RX_DROP_STATS_EN
        ,
        .rx_overflow_count(rx_overflow_count),
        .rx_bad_count     (rx_bad_count)
`endif
    );

    always #3 clk156 = ~clk156;

    // tready: 0 = held low, 1 = held high, 2 = random
    int   tready_mode = 1;
    logic rnd_ready   = 1'b1;
    assign m_if.tready = (tready_mode == 2) ? rnd_ready : (tready_mode == 1);
    always @(posedge clk156) begin
        #1 rnd_ready = ($urandom_range(0, 3) != 0);
    end

    beat_t sb[$];
    int    errors = 0;
    int    checks = 0;
    int    rx_beats = 0;
    int    bad_pulses = 0;
    int    ovf_pulses = 0;
    int    exp_bad = 0;
    int    exp_ovf = 0;
    logic  stalled_prev = 1'b0;
    beat_t held_prev;
    beat_t cur_beat;
    beat_t exp_beat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output compare: every accepted beat must be the next modelled beat.
    always @(negedge clk156) begin
        if (reset) begin
            stalled_prev = 1'b0;
        end else begin
            if (rx_bad_frame) bad_pulses++;
            if (rx_fifo_overflow) ovf_pulses++;
            cur_beat = {m_if.tlast, m_if.tkeep, m_if.tdata};
            if (stalled_prev) begin
                checks++;
                if (!m_if.tvalid || cur_beat != held_prev) begin
                    errors++;
                    $display("FAIL hold: got valid=%0b beat=%h expected valid=1 beat=%h",
                             m_if.tvalid, cur_beat, held_prev);
                end
            end
            if (m_if.tvalid && m_if.tready) begin
                checks++;
                rx_beats++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got beat=%h expected no beat", cur_beat);
                end else begin
                    exp_beat = sb.pop_front();
                    if (cur_beat != exp_beat) begin
                        errors++;
                        $display("FAIL beat: got last=%0b keep=%h data=%h expected last=%0b keep=%h data=%h",
                                 cur_beat.last, cur_beat.keep, cur_beat.data,
                                 exp_beat.last, exp_beat.keep, exp_beat.data);
                    end
                end
            end
            stalled_prev = m_if.tvalid && !m_if.tready;
            held_prev    = cur_beat;
        end
    end

    task automatic tick();
        @(posedge clk156);
        #1;
    endtask

    task automatic send_frame(input int len, input logic bad, input logic expect_drop,
                              input logic [63:0] base, input logic [7:0] last_keep);
        beat_t fr[$];
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = base + 64'(i);
            b.keep = (i == len - 1) ? last_keep : 8'hFF;
            b.last = (i == len - 1);
            s_if.tvalid = 1'b1;
            s_if.tdata  = b.data;
            s_if.tkeep  = b.keep;
            s_if.tlast  = b.last;
            s_if.tuser  = bad && b.last;
            fr.push_back(b);
            tick();
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        if (expect_drop) exp_ovf++;
        else if (bad) exp_bad++;
        else foreach (fr[i]) sb.push_back(fr[i]);
        $display("frame len=%0d bad=%0b drop=%0b base=%h", len, bad, expect_drop, base);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() > 0 && n < 2000) begin
            tick();
            n++;
        end
        check("drain_left", 64'(sb.size()), 64'd0);
        repeat (3) tick();
    endtask

    int b0, bp0, op0, len, wait_n;
    logic bad;

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        repeat (3) tick();
        @(negedge clk156);
        check("reset_tvalid", 64'(m_if.tvalid), 64'd0);
        check("reset_tlast", 64'(m_if.tlast), 64'd0);
        check("reset_tdata", m_if.tdata, 64'd0);
        check("reset_tkeep", 64'(m_if.tkeep), 64'd0);
        check("reset_ovf", 64'(rx_fifo_overflow), 64'd0);
        check("reset_bad", 64'(rx_bad_frame), 64'd0);
`ifdef RX_DROP_STATS_EN
        check("reset_ovf_count", 64'(rx_overflow_count), 64'd0);
        check("reset_bad_count", 64'(rx_bad_count), 64'd0);
`endif
        tick();
        reset = 1'b0;
        tick();

        // Good 8-beat frame and first-beat latency.
        b0 = rx_beats;
        send_frame(8, 1'b0, 1'b0, 64'h1000_0000_0000_0000, 8'h0F);
        @(negedge clk156);
        check("lat_c1_tvalid", 64'(m_if.tvalid), 64'd0);
        @(negedge clk156);
        check("lat_c2_tvalid", 64'(m_if.tvalid), 64'd1);
        check("lat_c2_tdata", m_if.tdata, 64'h1000_0000_0000_0000);
        check("lat_c2_tlast", 64'(m_if.tlast), 64'd0);
        wait_drain();
        check("good_beats", 64'(rx_beats - b0), 64'd8);

        // Bad frame followed by a good one.
        b0 = rx_beats;
        send_frame(4, 1'b1, 1'b0, 64'h2000_0000_0000_0000, 8'hFF);
        send_frame(3, 1'b0, 1'b0, 64'h3000_0000_0000_0000, 8'h03);
        wait_drain();
        check("bad_test_beats", 64'(rx_beats - b0), 64'd3);
        check("bad_test_pulses", 64'(bad_pulses), 64'd1);
        check("bad_test_ovf", 64'(ovf_pulses), 64'd0);

        // Overflow: second 10-beat frame cannot fit while the output is stalled.
        tready_mode = 0;
        b0 = rx_beats;
        send_frame(10, 1'b0, 1'b0, 64'h4000_0000_0000_0000, 8'h7F);
        send_frame(10, 1'b0, 1'b1, 64'h4100_0000_0000_0000, 8'hFF);
        repeat (4) tick();
        check("ovf_pulses", 64'(ovf_pulses), 64'd1);
        tready_mode = 1;
        wait_drain();
        check("ovf_beats", 64'(rx_beats - b0), 64'd10);
        send_frame(2, 1'b0, 1'b0, 64'h4200_0000_0000_0000, 8'h01);
        wait_drain();
        check("ovf_recover_beats", 64'(rx_beats - b0), 64'd12);

        // Backpressure pattern 1,0,0,1 during a 6-beat frame.
        b0 = rx_beats;
        send_frame(6, 1'b0, 1'b0, 64'h5000_0000_0000_0000, 8'h3F);
        tick();
        tready_mode = 0;
        tick();
        tick();
        tready_mode = 1;
        wait_drain();
        check("bp_beats", 64'(rx_beats - b0), 64'd6);

        // Random frames with random tready, throttled so the buffer never fills.
        tready_mode = 2;
        for (int f = 0; f < 200; f++) begin
            wait_n = 0;
            while (sb.size() > 3 && wait_n < 500) begin
                tick();
                wait_n++;
            end
            check("throttle_wait", 64'(sb.size() > 3), 64'd0);
            repeat ($urandom_range(0, 2)) tick();
            len = $urandom_range(1, 12);
            bad = ($urandom_range(0, 7) == 0);
            send_frame(len, bad, 1'b0, {$urandom(), $urandom()}, 8'($urandom_range(1, 255)));
        end
        tready_mode = 1;
        wait_drain();
        check("rand_bad_pulses", 64'(bad_pulses), 64'(exp_bad));
        check("rand_ovf_pulses", 64'(ovf_pulses), 64'(exp_ovf));

        // Reset with one stored frame and one partial frame in flight.
        tready_mode = 0;
        send_frame(5, 1'b0, 1'b0, 64'h6000_0000_0000_0000, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = 64'h7000_0000_0000_0000 + 64'(i);
            s_if.tkeep  = 8'hFF;
            s_if.tlast  = 1'b0;
            tick();
        end
        s_if.tvalid = 1'b0;
        reset = 1'b1;
        sb.delete();
        @(negedge clk156);
        check("rst_mid_tvalid", 64'(m_if.tvalid), 64'd0);
        tick();
        reset = 1'b0;
        tready_mode = 1;
        b0 = rx_beats;
        repeat (8) tick();
        check("rst_empty_beats", 64'(rx_beats - b0), 64'd0);
        check("rst_empty_tvalid", 64'(m_if.tvalid), 64'd0);
        send_frame(3, 1'b0, 1'b0, 64'h7000_0000_0000_0003, 8'h07);
        wait_drain();
        check("rst_tail_beats", 64'(rx_beats - b0), 64'd3);

        // Drop statistics: two overflowed and three bad frames.
        bp0 = bad_pulses;
        op0 = ovf_pulses;
        tready_mode = 0;
        send_frame(12, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 8'hFF);
        send_frame(6, 1'b0, 1'b1, 64'h8100_0000_0000_0000, 8'hFF);
        send_frame(6, 1'b0, 1'b1, 64'h8200_0000_0000_0000, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            send_frame(2, 1'b1, 1'b0, 64'h8300_0000_0000_0000 + 64'(i * 16), 8'hFF);
        end
        tready_mode = 1;
        wait_drain();
        check("stats_bad_pulses", 64'(bad_pulses - bp0), 64'd3);
        check("stats_ovf_pulses", 64'(ovf_pulses - op0), 64'd2);
`ifdef RX_DROP_STATS_EN
        check("stats_bad_count", 64'(rx_bad_count), 64'd3);
        check("stats_ovf_count", 64'(rx_overflow_count), 64'd2);
`endif
        check("final_bad_pulses", 64'(bad_pulses), 64'(exp_bad));
        check("final_ovf_pulses", 64'(ovf_pulses), 64'(exp_ovf));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rx_frame_buffer.md
RX_FRAME_BUFFER -- requirements
Module: rx_frame_buffer

Interface
REQ-001 Parameter: DEPTH_LOG2, default 9, log2 of buffer depth in 73-bit beats (512 beats = 4 KiB).
REQ-002 Port: clk156  in  1  single 156.25 MHz core clock; all logic in this domain.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: s_axis_tdata  in  64  RX beat data from the 10G MAC.
REQ-005 Port: s_axis_tkeep  in  8  byte enables.
REQ-006 Port: s_axis_tvalid  in  1  beat valid; the MAC cannot be stalled, so there is no s_axis_tready.
REQ-007 Port: s_axis_tlast  in  1  last beat of the frame.
REQ-008 Port: s_axis_tuser  in  1  sampled with tlast: 1 = bad frame (FCS, length or runt error).
REQ-009 Port: m_axis_tdata/tkeep/tvalid/tlast  out  64/8/1/1  good frames only, toward the RX output register slice.
REQ-010 Port: m_axis_tready  in  1  downstream ready.
REQ-011 Port: rx_fifo_overflow  out  1  one-cycle pulse per frame dropped for lack of space.
REQ-012 Port: rx_bad_frame  out  1  one-cycle pulse per frame dropped due to tuser.

Function
REQ-013 Operation: store-and-forward; no beat of a frame leaves until its good tlast has been written.
REQ-014 Storage word: {tlast, tkeep, tdata}, 73 bits.
- Pointers: wr_ptr, commit_ptr and rd_ptr, each DEPTH_LOG2+1 bits, wrapping modulo 2^(DEPTH_LOG2+1).
- Full when wr_ptr - rd_ptr == 2^DEPTH_LOG2.
REQ-015 Write FSM states: IDLE (between frames), PASS (storing a frame), DROP (discarding the rest of a frame).
REQ-016 IDLE/PASS, valid beat, buffer not full: write the beat, increment wr_ptr, go to PASS (or to IDLE if tlast).
REQ-017 Good frame (tlast=1, tuser=0) written: commit_ptr <= wr_ptr+1 in the same cycle.
REQ-018 Bad frame (tlast=1, tuser=1): wr_ptr <= commit_ptr, rx_bad_frame pulses, go to IDLE.
REQ-019 Valid beat while full: beat discarded, wr_ptr <= commit_ptr, rx_fifo_overflow pulses once.
- Next state is DROP, or IDLE if that beat had tlast.
REQ-020 In DROP, all beats are discarded without further pulses; the tlast beat returns the FSM to IDLE.
- A frame longer than 2^DEPTH_LOG2 beats is therefore always dropped.
REQ-021 Space check uses the registered rd_ptr: a beat read in cycle N frees space from cycle N+1.
- Simultaneous read and write in one cycle are always permitted.
REQ-022 Read side: committed data exists when rd_ptr != commit_ptr; one-cycle RAM read feeds an output register.
- First beat of a committed frame reaches m_axis_tvalid=1 exactly 2 cycles after its tlast write cycle.
REQ-023 Output handshake: while m_axis_tvalid=1 and m_axis_tready=0, m_axis_* hold stable.
REQ-024 Output throughput: with m_axis_tready held 1, one beat per cycle, back-to-back across frame boundaries.

Reset
REQ-025 Reset values: all pointers 0, FSM IDLE, m_axis_tvalid=0, m_axis_tlast=0, rx_fifo_overflow=0, rx_bad_frame=0.
- m_axis_tdata and m_axis_tkeep are 0.
REQ-026 Reset mid-frame discards all buffered and partial frames.
- After release, the first accepted beat is the first beat seen in IDLE; a tail of an interrupted frame is treated as a frame.

Configuration
REQ-027 With RX_DROP_STATS_EN defined: two extra 32-bit outputs, rx_overflow_count and rx_bad_count.
- Each increments on its pulse, saturates at 0xFFFFFFFF and resets to 0.
- Without the macro: the ports and counters do not exist.

Structure
REQ-028 Shared package (net_pkg): AXIS_DATA_W=64, AXIS_KEEP_W=8 and the write-FSM state enum.
REQ-029 Sub-module: rx_frame_buffer_ram, a simple dual-port 73-bit x 2^DEPTH_LOG2 RAM with registered read, one write and one read port.

Verification
REQ-030 Good frame: 8-beat frame, tuser=0, tready=1 -> same 8 beats out starting 2 cycles after the tlast write, tkeep/tlast intact.
REQ-031 Bad frame: 4-beat frame with tuser=1, then 3-beat good frame -> only the 3-beat frame out; rx_bad_frame pulses once.
REQ-032 Overflow: DEPTH_LOG2=4, tready=0, 10-beat good then 10-beat good -> second frame dropped, rx_fifo_overflow=1 for one cycle.
- After tready=1, exactly the first 10 beats appear.
REQ-033 Backpressure: tready toggles 1,0,0,1 during a 6-beat frame -> no beat lost or duplicated; data stable while stalled.
REQ-034 Wrap and reset: DEPTH_LOG2=4, 200 random frames (1-12 beats) -> scoreboard match across pointer wrap.
- Reset asserted mid-frame -> m_axis_tvalid=0 next cycle and buffer empty.
REQ-035 Stats (RX_DROP_STATS_EN): 3 bad and 2 overflowed frames -> rx_bad_count=3, rx_overflow_count=2.
